// File: rtl/bus_pkg.sv
// Shared bus constants for the serial system bus.
// Address/data widths and transfer-direction encodings.
package bus_pkg;
  localparam int   BUS_ADDR_W = 16;
  localparam int   BUS_DATA_W = 8;
  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;
endpackage

// File: rtl/bus_shift_reg.sv
// MSB-first SIPO/PISO shift register with a beat counter.
// The counter wraps after W beats; clr restarts it, counting a same-cycle shift.
module bus_shift_reg #(
  parameter int W = 8,
  localparam int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          shift,
  input  logic          sin,
  output logic [W-1:0]  q,
  output logic [CW-1:0] cnt
);

  // Parallel load wins; otherwise shift left and count beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= din;
      cnt <= '0;
    end else begin
      if (shift) q <= {q[W-2:0], sin};
      cnt <= (clr ? '0 : cnt) + CW'(shift);
    end
  end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave endpoint: address decode, local write/read strobes.
// Deserialises writes into s_wr_en; serialises local reads back on rd_bus.
module slave_port
  import bus_pkg::*;
#(
  parameter int                DEV_W      = 4,
  parameter logic [DEV_W-1:0]  DEVICE_ID  = 'h1,
  parameter int                RD_LATENCY = 1,
  parameter int                TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        mode,
  input  logic                        wr_bus,
  input  logic                        master_valid,
  output logic                        slave_ready,
  output logic                        rd_bus,
  output logic                        slave_valid,
  input  logic                        master_ready,
  output logic                        ack,
  output logic [BUS_ADDR_W-DEV_W-1:0] s_addr,
  output logic [BUS_DATA_W-1:0]       s_wr_data,
  output logic                        s_wr_en,
  output logic                        s_rd_en,
  input  logic [BUS_DATA_W-1:0]       s_rd_data
);

  localparam int AW  = BUS_ADDR_W - DEV_W;
  localparam int ACW = $clog2(BUS_ADDR_W);
  localparam int DCW = $clog2(BUS_DATA_W);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ADDR, S_WR_DATA, S_WRITE,
    S_RD_REQ, S_RD_WAIT, S_RD_DATA, S_SKIP
  } state_t;

  state_t st;
  logic   mode_q;
  logic [TW-1:0] to_cnt;
  logic [1:0]    lat_cnt;

  logic in_beat, out_beat;
  logic [BUS_ADDR_W-1:0] addr_q;
  logic [ACW-1:0]        addr_cnt;
  logic [DCW-1:0]        wdat_cnt;
  logic [DCW-1:0]        rdat_cnt;
  logic                  rd_msb;
  logic [BUS_DATA_W-2:0] rd_unused;

  logic addr_shift, wdat_shift, rd_cap;
  logic dev_done, dev_hit, addr_done, wdat_done, rd_done;
  logic active, abort;

  assign in_beat  = master_valid & slave_ready;
  assign out_beat = slave_valid & master_ready;

  assign addr_shift = in_beat &&
    (st == S_IDLE || st == S_DEV || st == S_ADDR);
  assign wdat_shift = in_beat && st == S_WR_DATA;
  assign rd_cap = st == S_RD_WAIT &&
    lat_cnt == 2'(RD_LATENCY - 1);

  assign dev_done  = in_beat && addr_cnt == ACW'(DEV_W - 1);
  assign dev_hit   = {addr_q[DEV_W-2:0], wr_bus} == DEVICE_ID;
  assign addr_done = in_beat && addr_cnt == ACW'(BUS_ADDR_W - 1);
  assign wdat_done = in_beat && wdat_cnt == DCW'(BUS_DATA_W - 1);
  assign rd_done   = out_beat && rdat_cnt == DCW'(BUS_DATA_W - 1);

  assign active = st == S_DEV || st == S_ADDR || st == S_WR_DATA;
  assign abort  = active && !in_beat && to_cnt == TW'(TIMEOUT - 1);

  assign s_addr = addr_q[AW-1:0];
  assign rd_bus = slave_valid & rd_msb;

  bus_shift_reg #(.W(BUS_ADDR_W)) u_addr (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (st == S_IDLE),
    .load  (1'b0),
    .din   ('0),
    .shift (addr_shift),
    .sin   (wr_bus),
    .q     (addr_q),
    .cnt   (addr_cnt)
  );

  bus_shift_reg #(.W(BUS_DATA_W)) u_wdat (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (st == S_IDLE),
    .load  (1'b0),
    .din   ('0),
    .shift (wdat_shift),
    .sin   (wr_bus),
    .q     (s_wr_data),
    .cnt   (wdat_cnt)
  );

  bus_shift_reg #(.W(BUS_DATA_W)) u_rdat (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (1'b0),
    .load  (rd_cap),
    .din   (s_rd_data),
    .shift (out_beat),
    .sin   (1'b0),
    .q     ({rd_msb, rd_unused}),
    .cnt   (rdat_cnt)
  );

  // Transaction FSM with registered handshake, ack and strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= S_IDLE;
      mode_q      <= MODE_READ;
      ack         <= 1'b0;
      s_wr_en     <= 1'b0;
      s_rd_en     <= 1'b0;
      slave_valid <= 1'b0;
      slave_ready <= 1'b1;
      to_cnt      <= '0;
      lat_cnt     <= '0;
    end else begin
      s_wr_en <= 1'b0;
      s_rd_en <= 1'b0;
      if (active && !in_beat) to_cnt <= to_cnt + TW'(1);
      else                    to_cnt <= '0;
      if (abort) begin
        st          <= S_IDLE;
        ack         <= 1'b0;
        slave_ready <= 1'b1;
      end else begin
        unique case (st)
          S_IDLE: begin
            if (in_beat) begin
              mode_q <= mode;
              st     <= S_DEV;
            end
          end
          S_DEV: begin
            if (dev_done) begin
              if (dev_hit) begin
                ack <= 1'b1;
                st  <= S_ADDR;
              end else begin
                st  <= S_SKIP;
              end
            end
          end
          S_ADDR: begin
            if (addr_done) begin
              if (mode_q == MODE_WRITE) begin
                st <= S_WR_DATA;
              end else begin
                st          <= S_RD_REQ;
                s_rd_en     <= 1'b1;
                slave_ready <= 1'b0;
              end
            end
          end
          S_WR_DATA: begin
            if (wdat_done) begin
              st          <= S_WRITE;
              s_wr_en     <= 1'b1;
              slave_ready <= 1'b0;
            end
          end
          S_WRITE: begin
            st          <= S_IDLE;
            ack         <= 1'b0;
            slave_ready <= 1'b1;
          end
          S_RD_REQ: begin
            lat_cnt <= '0;
            st      <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (rd_cap) begin
              st          <= S_RD_DATA;
              slave_valid <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_RD_DATA: begin
            if (rd_done) begin
              st          <= S_IDLE;
              slave_valid <= 1'b0;
              ack         <= 1'b0;
              slave_ready <= 1'b1;
            end
          end
          S_SKIP: begin
            if (!master_valid) st <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: vector table plus corner sequences.
// Models a latency-1 local memory and counts strobes.
module tb_slave_port;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       mode = 1'b0;
  logic       wr_bus = 1'b0;
  logic       master_valid = 1'b0;
  logic       master_ready = 1'b0;
  logic       slave_ready, rd_bus, slave_valid, ack;
  logic       s_wr_en, s_rd_en;
  logic [11:0] s_addr;
  logic [7:0]  s_wr_data;
  logic [7:0]  s_rd_data = 8'h00;
  logic [7:0]  rd_val = 8'h00;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [11:0] wr_addr = '0;
  logic [11:0] rd_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        ack_seen = 1'b0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ack;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  slave_port dut (
    .clk          (clk),
    .rstn         (rstn),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .rd_bus       (rd_bus),
    .slave_valid  (slave_valid),
    .master_ready (master_ready),
    .ack          (ack),
    .s_addr       (s_addr),
    .s_wr_data    (s_wr_data),
    .s_wr_en      (s_wr_en),
    .s_rd_en      (s_rd_en),
    .s_rd_data    (s_rd_data)
  );

  always @(posedge clk) s_rd_data <= s_rd_en ? rd_val : 8'h00;

  always @(posedge clk) begin
    if (s_wr_en) begin
      wr_cnt++;
      wr_addr = s_addr;
      wr_data = s_wr_data;
    end
    if (s_rd_en) begin
      rd_cnt++;
      rd_addr = s_addr;
    end
    if (ack) ack_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic send(input logic [15:0] v, input int n,
                      inout int to);
    for (int i = n - 1; i >= 0; i--) begin
      int g;
      g = 0;
      @(negedge clk);
      master_valid = 1'b1;
      wr_bus = v[i];
      while (!slave_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) to++;
      @(posedge clk);
    end
  endtask

  task automatic rcv(input logic [3:0] pat, input int nb,
                     output logic [7:0] b, output int se);
    int n, k, g;
    logic prev, stl;
    n = 0; k = 0; g = 0; prev = 0; stl = 0; b = 0; se = 0;
    while (n < nb && g < 200) begin
      @(negedge clk);
      g++;
      master_ready = 1'b0;
      if (slave_valid) begin
        if (stl && rd_bus !== prev) se++;
        prev = rd_bus;
        master_ready = pat[3 - (k % 4)];
        k++;
        if (master_ready) begin
          b = {b[6:0], rd_bus};
          n++;
          stl = 0;
        end else begin
          stl = 1;
        end
      end
    end
    chk("rcv_beats", n, nb);
    @(posedge clk);
    #1 master_ready = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    int w0, r0, to, se;
    logic [7:0] b;
    w0 = wr_cnt; r0 = rd_cnt; to = 0; se = 0; b = 0;
    ack_seen = 1'b0;
    rd_val = v.data;
    mode = v.wr;
    send(v.addr >> 11, 5, to);
    #1 chk("ack_before_beat6", ack, v.ack);
    send(v.addr, 11, to);
    if (v.wr) send({8'h00, v.data}, 8, to);
    @(negedge clk) master_valid = 1'b0;
    if (!v.wr && v.ack) begin
      rcv(4'b1111, 8, b, se);
      chk("rd_byte", b, v.data);
      @(negedge clk);
      chk("valid_drop", slave_valid, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("send_stall", to, 0);
    chk("wr_strobes", wr_cnt - w0, v.wr && v.ack);
    chk("rd_strobes", rd_cnt - r0, !v.wr && v.ack);
    if (v.ack && v.wr) begin
      chk("wr_addr", wr_addr, v.addr[11:0]);
      chk("wr_data", wr_data, v.data);
    end
    if (v.ack && !v.wr) chk("rd_addr", rd_addr, v.addr[11:0]);
    chk("ack_seen", ack_seen, v.ack);
    chk("idle", {slave_ready, ack, slave_valid}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int to, se, w0;
    logic [7:0] b;
    tbl[0] = '{1'b1, 16'h1234, 8'hA5, 1'b1};
    tbl[1] = '{1'b0, 16'h10F0, 8'h3C, 1'b1};
    tbl[2] = '{1'b0, 16'h2ABC, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 16'h1001, 8'h5A, 1'b1};
    tbl[4] = '{1'b0, 16'h1FFF, 8'h81, 1'b1};
    tbl[5] = '{1'b1, 16'h0FFF, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_ctl",
        {slave_ready, ack, slave_valid, s_wr_en, s_rd_en, rd_bus},
        6'b100000);
    chk("reset_regs", {s_addr, s_wr_data}, 20'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) do_txn(tbl[i]);

    // Read with master_ready stalls.
    to = 0;
    mode = 1'b0;
    rd_val = 8'h96;
    w0 = rd_cnt;
    send(16'h1055, 16, to);
    @(negedge clk) master_valid = 1'b0;
    rcv(4'b1001, 8, b, se);
    chk("stall_byte", b, 8'h96);
    chk("stall_hold", se, 0);
    chk("stall_rd_addr", rd_addr, 12'h055);
    chk("stall_rd_cnt", rd_cnt - w0, 1);
    repeat (2) @(negedge clk);

    // Timeout after 7 address bits.
    w0 = wr_cnt;
    mode = 1'b1;
    send(16'h1234 >> 9, 7, to);
    @(negedge clk) master_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("to_still_ack", ack, 1'b1);
    repeat (10) @(negedge clk);
    chk("to_abort", {slave_ready, ack}, 2'b10);
    chk("to_no_wr", wr_cnt - w0, 0);
    do_txn('{1'b1, 16'h1001, 8'h3E, 1'b1});

    // Back-to-back writes.
    w0 = wr_cnt;
    mode = 1'b1;
    send(16'h1001, 16, to);
    send(16'h00C3, 8, to);
    send(16'h1002, 16, to);
    send(16'h0077, 8, to);
    @(negedge clk) master_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_cnt", wr_cnt - w0, 2);
    chk("b2b_addr", wr_addr, 12'h002);
    chk("b2b_data", wr_data, 8'h77);

    // Reset in the middle of read data.
    mode = 1'b0;
    rd_val = 8'hF0;
    w0 = wr_cnt;
    send(16'h1055, 16, to);
    @(negedge clk) master_valid = 1'b0;
    rcv(4'b1111, 3, b, se);
    chk("pre_rst_bits", b[2:0], 3'b111);
    chk("pre_rst_bus", rd_bus, 1'b1);
    #1 rstn = 1'b0;
    #1 chk("rst_async", {slave_valid, ack, rd_bus, slave_ready}, 4'b0001);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    chk("rst_idle", {slave_ready, ack, slave_valid}, 3'b100);
    chk("send_stall_all", to, 0);
    do_txn('{1'b1, 16'h1ABC, 8'hC3, 1'b1});
    chk("rst_wr_total", wr_cnt - w0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Bus-side endpoint that consumes the serial transactions issued by the master port on the system bus.
- Receives a 16-bit address MSB-first and decodes the upper DEV_W bits against DEVICE_ID, asserting ack on a match.
- Then either deserialises 8 write bits and pulses a local write strobe, or performs a local read and serialises 8 bits back.
- Sits between the bus interconnect and one slave memory or peripheral.

Parameters:
DEVICE_ID, 4'h1, device select compared against address bits [15:16-DEV_W]
DEV_W, 4, number of device-select bits at the top of the 16-bit bus address
RD_LATENCY, 1, cycles from s_rd_en to valid s_rd_data (1..4)
TIMEOUT, 64, idle cycles without a handshake mid-transaction before abort

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock; reset is asynchronous and active-low
mode  in  1  bus transfer direction, 1=write, 0=read; sampled on the first address beat
wr_bus  in  1  serial address/write-data bit from master, MSB first
master_valid  in  1  master presents a valid bit on wr_bus
slave_ready  out  1  slave accepts the wr_bus bit this cycle
rd_bus  out  1  serial read-data bit to master, MSB first
slave_valid  out  1  rd_bus holds a valid bit
master_ready  in  1  master accepts the rd_bus bit this cycle
ack  out  1  device select matched; held until the transaction ends
s_addr  out  16-DEV_W  local address to the device
s_wr_data  out  8  local write data
s_wr_en  out  1  one-cycle local write strobe
s_rd_en  out  1  one-cycle local read strobe
s_rd_data  in  8  local read data, valid RD_LATENCY cycles after s_rd_en

Behaviour:
- Definitions: in-beat = master_valid & slave_ready; out-beat = slave_valid & master_ready. All state, counters and registers are flops with async rstn.
- Reset values: state IDLE; ack, s_wr_en, s_rd_en, slave_valid, rd_bus all 0; slave_ready 1; s_addr and s_wr_data 0; counters 0.
- IDLE: slave_ready=1. On an in-beat: shift in address bit 15, latch mode, bit count=1, go DEV.
- DEV: slave_ready=1; shift one bit per in-beat. On the beat completing DEV_W bits, compare with DEVICE_ID:
  - match: ack=1 from the next cycle, go ADDR;
  - mismatch: go SKIP.
- ack timing: with DEV_W=4, ack is high before beat 6, which is when the master samples it.
- ADDR: shift remaining bits until 16 have been received. Then go WR_DATA if mode=1, else RD_REQ. s_addr = low 16-DEV_W address bits.
- WR_DATA: slave_ready=1; shift 8 bits into s_wr_data. After the 8th beat go WRITE.
- WRITE: s_wr_en=1 for exactly one cycle with s_addr and s_wr_data stable; slave_ready=0; then go IDLE and clear ack.
- RD_REQ: s_rd_en=1 for one cycle; slave_ready=0; go RD_WAIT.
- RD_WAIT: wait RD_LATENCY cycles, capture s_rd_data into the shift register, go RD_DATA.
- RD_DATA: slave_valid=1 and rd_bus=shift[7]; shift left on each out-beat. Stall indefinitely while master_ready=0; no timeout applies here. After the 8th out-beat go IDLE, clear ack, set slave_valid=0.
- SKIP: ack=0, slave_ready=1, absorb bits, no local strobes. Return to IDLE on the first cycle with master_valid=0.
- Timeout: in DEV, ADDR or WR_DATA, a counter increments on every cycle without an in-beat and clears on each in-beat. At TIMEOUT-1 it aborts to IDLE: ack cleared, no s_wr_en.
- Back-to-back: an in-beat in IDLE on the cycle after WRITE starts a new transaction.
- Reset mid-transaction: immediate IDLE. Strobes drop asynchronously; no partial write is ever issued.
- Widths: bit counter 4 bits (0..15), timeout counter $clog2(TIMEOUT) bits, latency counter 2 bits.

Decomposition:
- Shared package bus_pkg: BUS_ADDR_W=16, BUS_DATA_W=8, MODE_WRITE=1 and MODE_READ=0 constants. The state enum stays local to the module.
- One natural sub-module, bus_shift_reg: parameterised-width SIPO/PISO shift register with a bit counter. Instantiated for the address, write data and read data.

Test Plan:
- DEVICE_ID=1, write to 0x1234 with data 0xA5, slave_ready observed → ack high before beat 6; exactly one s_wr_en with s_addr=0x234 and s_wr_data=0xA5.
- Read from 0x10F0 with s_rd_data=0x3C, master_ready=1 → one s_rd_en, s_addr=0x0F0; rd_bus bits 0,0,1,1,1,1,0,0 with slave_valid on 8 beats; then IDLE.
- Address 0x2ABC → ack stays 0 and no strobes; IDLE once master_valid falls; the following write to 0x1001 succeeds.
- Read of 0x1055 with master_ready toggling 1,0,0,1 → rd_bus holds each bit during stalls; byte received intact.
- Write where master_valid stops after 7 address bits → abort to IDLE after 64 idle cycles; no s_wr_en; the next transaction works.
- rstn asserted in RD_DATA after 3 bits → slave_valid, ack and rd_bus are 0 immediately; IDLE after release.
